load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit over a one-cycle registered-read word RAM.
// Optional LSU_MISALIGN_TRAP_EN: fault on misaligned half/word accesses instead of force-aligning.
module load_store_unit #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  fault,
    output logic [addr_width-1:0] ram_daddr,
    output logic                  ram_MemRead,
    output logic                  ram_MemWrite,
    output logic [data_width-1:0] ram_ddata_w,
    input  logic [data_width-1:0] ram_ddata_r
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD} state_t;

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    fault_q, fault_d;
    logic [data_width-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                    mem_read, mem_write;
    logic [data_width-1:0]   wdata_out;
    logic [data_width-1:0]   load_ext;
    logic [data_width-1:0]   merged;
    logic [1:0]              off_eff;
    logic                    illegal;
    logic                    bad_req;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:addr_width+2];

    // Low address bits kept for lane selection; wider accesses drop the bits they ignore.
    always_comb begin
        off_eff = 2'b00;
        case (req_funct3[1:0])
            2'b00:   off_eff = req_addr[1:0];
            2'b01:   off_eff = {req_addr[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end

    assign illegal = req_write ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                               : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0])
                   || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign bad_req  = illegal || misalign;
`else
    assign bad_req  = illegal;
`endif

    always_comb begin
        load_ext = ram_ddata_r;
        case (funct3_q)
            3'b000: load_ext = {{24{ram_ddata_r[8*off_q+7]}}, ram_ddata_r[8*off_q +: 8]};
            3'b100: load_ext = {24'h0, ram_ddata_r[8*off_q +: 8]};
            3'b001: load_ext = off_q[1] ? {{16{ram_ddata_r[31]}}, ram_ddata_r[31:16]}
                                        : {{16{ram_ddata_r[15]}}, ram_ddata_r[15:0]};
            3'b101: load_ext = off_q[1] ? {16'h0, ram_ddata_r[31:16]}
                                        : {16'h0, ram_ddata_r[15:0]};
            default: load_ext = ram_ddata_r;
        endcase
    end

    always_comb begin
        merged = ram_ddata_r;
        if (funct3_q[1:0] == 2'b00) begin
            merged[8*off_q +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        fault_d     = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        wdata_out   = req_wdata;
        ram_daddr   = addr_q;
        case (state_q)
            IDLE: begin
                ram_daddr = req_addr[addr_width+1:2];
                if (req_valid) begin
                    if (bad_req) begin
                        fault_d = 1'b1;
                    end else if (req_write && req_funct3[1:0] == 2'b10) begin
                        mem_write = 1'b1;
                    end else begin
                        // Loads and partial stores both need the current word first.
                        mem_read = 1'b1;
                        addr_d   = req_addr[addr_width+1:2];
                        off_d    = off_eff;
                        funct3_d = req_funct3;
                        wdata_d  = req_wdata[15:0];
                        state_d  = req_write ? RMW_RD : LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                rsp_rdata_d = load_ext;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            RMW_RD: begin
                mem_write = 1'b1;
                wdata_out = merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Reset gates the strobes combinationally so an in-flight read-modify-write never lands.
    assign ram_MemRead  = mem_read && !RESET;
    assign ram_MemWrite = mem_write && !RESET;
    assign ram_ddata_w  = wdata_out;
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a word RAM model.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic [9:0]  ram_daddr;
    logic        ram_MemRead;
    logic        ram_MemWrite;
    logic [31:0] ram_ddata_w;
    logic [31:0] ram_ddata_r;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_q [$];
    int vectors    = 0;
    int miscompares = 0;
    int rd_cnt     = 0;
    int wr_cnt     = 0;
    int fault_cnt  = 0;
    int fault_exp  = 0;
    int overlap    = 0;

    always #5 CLK = ~CLK;

    load_store_unit #(.addr_width(10), .data_width(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
        .ram_daddr(ram_daddr), .ram_MemRead(ram_MemRead), .ram_MemWrite(ram_MemWrite),
        .ram_ddata_w(ram_ddata_w), .ram_ddata_r(ram_ddata_r)
    );

    always @(posedge CLK) begin
        if (ram_MemRead)  ram_ddata_r <= mem[ram_daddr];
        if (ram_MemWrite) mem[ram_daddr] <= ram_ddata_w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (ram_MemRead) rd_cnt++;
        if (ram_MemWrite) wr_cnt++;
        if (ram_MemRead && ram_MemWrite) overlap++;
        if (fault) fault_cnt++;
        if (rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            else chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("busy_timeout", {31'h0, busy}, 32'd0);
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        drive(w, f3, a, d);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        wait_idle();
        exp_q.push_back(exp);
        issue(1'b0, f3, a, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        RESET = 1'b1;
        drive(1'b0, 3'b010, 32'h40, 32'h0);
        #2;
        chk("reset_strobe_gate", {30'h0, ram_MemRead, ram_MemWrite}, 32'd0);
        tick(); tick();
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("reset_fault", {31'h0, fault}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        req_valid = 1'b0;
        RESET = 1'b0;
        tick();

        // SW completes in the accepting cycle
        drive(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        #1;
        chk("sw_memwrite", {30'h0, ram_MemRead, ram_MemWrite}, 32'd1);
        chk("sw_daddr", {22'h0, ram_daddr}, 32'h10);
        chk("sw_wdata", ram_ddata_w, 32'hDEADBEEF);
        tick();
        req_valid = 1'b0;
        chk("sw_busy", {31'h0, busy}, 32'd0);
        chk("sw_mem", mem[16], 32'hDEADBEEF);

        // LW latency: accept N, busy N+1, rsp_valid N+2
        exp_q.push_back(32'hDEADBEEF);
        drive(1'b0, 3'b010, 32'h40, 32'h0);
        #1;
        chk("lw_memread", {30'h0, ram_MemRead, ram_MemWrite}, 32'd2);
        tick();
        req_valid = 1'b0;
        chk("lw_busy_n1", {31'h0, busy}, 32'd1);
        chk("lw_rsp_n1", {31'h0, rsp_valid}, 32'd0);
        tick();
        chk("lw_busy_n2", {31'h0, busy}, 32'd0);
        chk("lw_rsp_n2", {31'h0, rsp_valid}, 32'd1);
        chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("lw_rsp_n3", {31'h0, rsp_valid}, 32'd0);
        chk("lw_rdata_hold", rsp_rdata, 32'hDEADBEEF);

        load(3'b000, 32'h43, 32'hFFFFFFDE);
        load(3'b100, 32'h43, 32'h000000DE);
        load(3'b001, 32'h40, 32'hFFFFBEEF);
        load(3'b101, 32'h40, 32'h0000BEEF);
        load(3'b000, 32'h40, 32'hFFFFFFEF);
        load(3'b100, 32'h41, 32'h000000BE);

        // SB read-modify-write
        wait_idle();
        rd_cnt = 0; wr_cnt = 0;
        issue(1'b1, 3'b000, 32'h41, 32'h000000AA);
        chk("sb_busy_n1", {31'h0, busy}, 32'd1);
        tick();
        chk("sb_busy_n2", {31'h0, busy}, 32'd0);
        tick();
        chk("sb_rd_cnt", rd_cnt, 32'd1);
        chk("sb_wr_cnt", wr_cnt, 32'd1);
        chk("sb_mem", mem[16], 32'hDEADAAEF);

        issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        issue(1'b1, 3'b001, 32'h42, 32'h00001234);
        tick();
        chk("sh_mem", mem[16], 32'h1234BEEF);
        load(3'b001, 32'h42, 32'h00001234);
        load(3'b000, 32'h43, 32'h00000012);

        // LW 0x41: trap or force-align
        wait_idle();
        rd_cnt = 0; wr_cnt = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_exp++;
        drive(1'b0, 3'b010, 32'h41, 32'h0);
        #1;
        chk("mis_no_strobe", {30'h0, ram_MemRead, ram_MemWrite}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("mis_fault", {31'h0, fault}, 32'd1);
        chk("mis_no_rsp", {31'h0, rsp_valid}, 32'd0);
        tick();
        chk("mis_fault_pulse", {31'h0, fault}, 32'd0);
        chk("mis_rd_cnt", rd_cnt, 32'd0);
`else
        load(3'b010, 32'h41, 32'h1234BEEF);
        load(3'b001, 32'h43, 32'h00001234);
        load(3'b101, 32'h41, 32'h0000BEEF);
`endif

        // Illegal funct3 on a load and on a store
        wait_idle();
        fault_exp++;
        drive(1'b0, 3'b011, 32'h40, 32'h0);
        #1;
        chk("ill_ld_no_strobe", {30'h0, ram_MemRead, ram_MemWrite}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("ill_ld_fault", {31'h0, fault}, 32'd1);
        fault_exp++;
        drive(1'b1, 3'b100, 32'h40, 32'h0);
        #1;
        chk("ill_st_no_strobe", {30'h0, ram_MemRead, ram_MemWrite}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("ill_st_fault", {31'h0, fault}, 32'd1);
        chk("ill_st_no_rsp", {31'h0, rsp_valid}, 32'd0);
        tick();
        chk("ill_mem", mem[16], 32'h1234BEEF);

        // Upper address bits wrap onto the same word
        issue(1'b1, 3'b010, 32'h00001040, 32'h0BADF00D);
        load(3'b010, 32'h40, 32'h0BADF00D);

        // Reset during RMW_RD aborts the write
        wait_idle();
        wr_cnt = 0;
        issue(1'b1, 3'b000, 32'h40, 32'h000000FF);
        RESET = 1'b1;
        #1;
        chk("rmw_reset_gate", {31'h0, ram_MemWrite}, 32'd0);
        tick();
        RESET = 1'b0;
        chk("rmw_reset_busy", {31'h0, busy}, 32'd0);
        chk("rmw_reset_rdata", rsp_rdata, 32'h0);
        tick(); tick();
        chk("rmw_reset_wr_cnt", wr_cnt, 32'd0);
        chk("rmw_reset_mem", mem[16], 32'h0BADF00D);

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("fault_count", fault_cnt, fault_exp);
        chk("rd_wr_overlap", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
